yarvi_bus_xbar: RTL and testbench

//  N-master to 1-slave bus arbiter for the yarvi SoC. Its masters are htif plus one or more harts.
//  - Arbitrates requests round-robin and forwards them to the memory/slave port.
//  - Routes in-order read responses back to the requester through a tag FIFO.
//  - Hosts the control register at CTRL_ADDR, which drives per-hart reset bits.
//  - Replaces the fixed single-master wiring and the single htif_reset flop.

---
 rtl/yarvi_bus_xbar.sv | 145 ++++++++++++++
 tb/tb_yarvi_bus_xbar.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yarvi_bus_xbar.sv
// N-master to 1-slave bus arbiter: round-robin grant, in-order read response routing
// through a tag FIFO, and the hart reset control register.
module yarvi_bus_xbar #(
  parameter int unsigned        N_MASTERS  = 2,
  parameter int unsigned        N_HARTS    = 1,
  parameter int unsigned        FIFO_DEPTH = 4,
  parameter logic [31:0]        CTRL_ADDR  = 32'hFFFF_FFFC,
  parameter logic [N_HARTS-1:0] RESET_INIT = '0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  output logic [N_MASTERS-1:0]      m_req_ready,
  input  logic [N_MASTERS-1:0]      m_req_read,
  input  logic [N_MASTERS-1:0]      m_req_write,
  input  logic [32*N_MASTERS-1:0]   m_req_address,
  input  logic [32*N_MASTERS-1:0]   m_req_data,
  output logic [N_MASTERS-1:0]      m_res_valid,
  output logic [31:0]               m_res_data,
  input  logic                      s_req_ready,
  output logic                      s_req_read,
  output logic                      s_req_write,
  output logic [31:0]               s_req_address,
  output logic [31:0]               s_req_data,
  input  logic                      s_res_valid,
  input  logic [31:0]               s_res_data,
  output logic [N_HARTS-1:0]        hart_reset,
  output logic                      err_orphan
);

  localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [N_MASTERS-1:0] req;
  logic [31:0]          addr_arr [N_MASTERS];
  logic [31:0]          data_arr [N_MASTERS];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
    assign req[i]      = m_req_read[i] | m_req_write[i];
    assign addr_arr[i] = m_req_address[32*i +: 32];
    assign data_arr[i] = m_req_data[32*i +: 32];
  end

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt;
  logic             gnt_any;

  // First requester at or after the round-robin pointer; lowest offset wins.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = int'(N_MASTERS) - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= int'(N_MASTERS)) idx = idx - int'(N_MASTERS);
      if (req[IDX_W'(idx)]) begin
        gnt     = IDX_W'(idx);
        gnt_any = 1'b1;
      end
    end
  end

  logic [31:0] g_addr;
  logic [31:0] g_data;
  logic        g_wr;
  logic        g_rd;
  logic        is_ctrl;

  assign g_addr  = addr_arr[gnt];
  assign g_data  = data_arr[gnt];
  assign g_wr    = m_req_write[gnt];
  assign g_rd    = m_req_read[gnt] & ~g_wr;
  assign is_ctrl = (g_addr == CTRL_ADDR);

  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [IDX_W-1:0] tag_mem [FIFO_DEPTH];
  logic             fifo_empty;
  logic             fifo_full;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // Control reads wait for an empty FIFO so they never collide with a slave response.
  logic accept;
  always_comb begin
    accept = 1'b0;
    if (gnt_any) begin
      if (is_ctrl)   accept = g_wr | fifo_empty;
      else if (g_wr) accept = s_req_ready;
      else           accept = s_req_ready & ~fifo_full;
    end
  end

  logic push;
  logic pop;
  logic ctrl_rd;
  logic ctrl_wr;

  assign m_req_ready   = accept ? (N_MASTERS'(1) << gnt) : '0;
  assign s_req_read    = accept & g_rd & ~is_ctrl;
  assign s_req_write   = accept & g_wr & ~is_ctrl;
  assign s_req_address = g_addr;
  assign s_req_data    = g_data;
  assign push          = s_req_read;
  assign pop           = s_res_valid & ~fifo_empty;
  assign ctrl_rd       = accept & g_rd & is_ctrl;
  assign ctrl_wr       = accept & g_wr & is_ctrl;

  always_ff @(posedge clock) begin
    if (push) tag_mem[wr_ptr[PTR_W-1:0]] <= gnt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      m_res_valid <= '0;
      m_res_data  <= '0;
      hart_reset  <= RESET_INIT;
      err_orphan  <= 1'b0;
    end else begin
      if (accept) rr_ptr <= (gnt == IDX_W'(N_MASTERS - 1)) ? '0 : gnt + IDX_W'(1);
      if (push)   wr_ptr <= wr_ptr + CNT_W'(1);
      if (pop)    rd_ptr <= rd_ptr + CNT_W'(1);

      // Responses are single-cycle pulses; masters cannot back-pressure them.
      m_res_valid <= '0;
      if (pop) begin
        m_res_valid <= N_MASTERS'(1) << tag_mem[rd_ptr[PTR_W-1:0]];
        m_res_data  <= s_res_data;
      end else if (ctrl_rd) begin
        m_res_valid <= N_MASTERS'(1) << gnt;
        m_res_data  <= 32'(hart_reset);
      end

      if (ctrl_wr) hart_reset <= g_data[N_HARTS-1:0];
      if (s_res_valid && fifo_empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_yarvi_bus_xbar.sv
// Self-checking bench for yarvi_bus_xbar: vector table for grant/ready decode plus
// hand sequences, with a response scoreboard fed from the bench's own tag model.
module tb_yarvi_bus_xbar;

  localparam logic [31:0] CTRL = 32'hFFFF_FFFC;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  m_req_ready;
  logic [1:0]  m_req_read;
  logic [1:0]  m_req_write;
  logic [63:0] m_req_address;
  logic [63:0] m_req_data;
  logic [1:0]  m_res_valid;
  logic [31:0] m_res_data;
  logic        s_req_ready;
  logic        s_req_read;
  logic        s_req_write;
  logic [31:0] s_req_address;
  logic [31:0] s_req_data;
  logic        s_res_valid;
  logic [31:0] s_res_data;
  logic [0:0]  hart_reset;
  logic        err_orphan;

  yarvi_bus_xbar #(
    .N_MASTERS(2), .N_HARTS(1), .FIFO_DEPTH(4), .CTRL_ADDR(CTRL), .RESET_INIT(1'b0)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .m_req_ready(m_req_ready), .m_req_read(m_req_read), .m_req_write(m_req_write),
    .m_req_address(m_req_address), .m_req_data(m_req_data),
    .m_res_valid(m_res_valid), .m_res_data(m_res_data),
    .s_req_ready(s_req_ready), .s_req_read(s_req_read), .s_req_write(s_req_write),
    .s_req_address(s_req_address), .s_req_data(s_req_data),
    .s_res_valid(s_res_valid), .s_res_data(s_res_data),
    .hart_reset(hart_reset), .err_orphan(err_orphan)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        srdy;
    logic [1:0]  e_rdy;
    logic        e_sr;
    logic        e_sw;
    logic [31:0] e_sa;
    logic [31:0] e_sd;
    logic        e_hart;
  } vec_t;

  resp_t exp_q[$];
  int    tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  vec_t  vt [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [31:0] d);
    resp_t e;
    e.idx  = idx;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    m_req_read  = 2'b00;
    m_req_write = 2'b00;
    s_req_ready = 1'b1;
    s_res_valid = 1'b0;
  endtask

  task automatic set_m(input int m, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m_req_read[0] = rd; m_req_write[0] = wr;
      m_req_address[31:0] = a; m_req_data[31:0] = d;
    end else begin
      m_req_read[1] = rd; m_req_write[1] = wr;
      m_req_address[63:32] = a; m_req_data[63:32] = d;
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    s_res_valid = 1'b0;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  // Slave returns data for the oldest outstanding read the bench has recorded.
  task automatic slave_resp(input logic [31:0] d);
    s_res_valid = 1'b1;
    s_res_data  = d;
    if (tag_q.size() > 0) push_exp(tag_q.pop_front(), d);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clock);
      #1;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  resp_t      mon_e;
  logic [1:0] mon_oh;

  always @(negedge clock) begin
    if (reset_n && m_res_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_response: got valid %b data 0x%0h, expected none",
                 m_res_valid, m_res_data);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_oh = 2'b00;
        mon_oh[mon_e.idx[0]] = 1'b1;
        check("res_valid", 32'(m_res_valid), 32'(mon_oh));
        check("res_data", m_res_data, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    //         rd     wr     a0      a1      d0      d1      srdy  e_rdy  sr    sw    e_sa    e_sd    hart
    vt[0] = '{2'b00, 2'b00, 32'h0,  32'h0,  32'h0,  32'h0,  1'b1, 2'b00, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0};
    vt[1] = '{2'b00, 2'b11, 32'h10, 32'h20, 32'h11, 32'h22, 1'b1, 2'b01, 1'b0, 1'b1, 32'h10, 32'h11, 1'b0};
    vt[2] = '{2'b00, 2'b11, 32'h10, 32'h20, 32'h11, 32'h22, 1'b1, 2'b10, 1'b0, 1'b1, 32'h20, 32'h22, 1'b0};
    vt[3] = '{2'b00, 2'b11, 32'h10, 32'h20, 32'h11, 32'h22, 1'b0, 2'b00, 1'b0, 1'b0, 32'h10, 32'h11, 1'b0};
    vt[4] = '{2'b00, 2'b10, 32'h0,  32'h20, 32'h0,  32'h22, 1'b0, 2'b00, 1'b0, 1'b0, 32'h20, 32'h22, 1'b0};
    vt[5] = '{2'b00, 2'b10, 32'h0,  32'h20, 32'h0,  32'h22, 1'b1, 2'b10, 1'b0, 1'b1, 32'h20, 32'h22, 1'b0};
    vt[6] = '{2'b01, 2'b01, 32'h30, 32'h0,  32'h33, 32'h0,  1'b1, 2'b01, 1'b0, 1'b1, 32'h30, 32'h33, 1'b0};
    vt[7] = '{2'b00, 2'b10, 32'h0,  CTRL,   32'h0,  32'h1,  1'b0, 2'b10, 1'b0, 1'b0, CTRL,   32'h1,  1'b0};
    vt[8] = '{2'b00, 2'b11, CTRL,   32'h40, 32'h0,  32'h44, 1'b1, 2'b01, 1'b0, 1'b0, CTRL,   32'h0,  1'b1};
    vt[9] = '{2'b00, 2'b11, 32'h50, 32'h60, 32'h55, 32'h66, 1'b1, 2'b10, 1'b0, 1'b1, 32'h60, 32'h66, 1'b0};

    idle();
    m_req_address = '0;
    m_req_data    = '0;
    s_res_data    = '0;
    reset_n       = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_res_valid", 32'(m_res_valid), 32'd0);
    check("rst_res_data", m_res_data, 32'd0);
    check("rst_hart", 32'(hart_reset), 32'd0);
    check("rst_err", 32'(err_orphan), 32'd0);
    reset_n = 1'b1;

    // Single-cycle grant/ready decode, with the round-robin pointer carried between rows.
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      m_req_read    = vt[i].rd;
      m_req_write   = vt[i].wr;
      m_req_address = {vt[i].a1, vt[i].a0};
      m_req_data    = {vt[i].d1, vt[i].d0};
      s_req_ready   = vt[i].srdy;
      sample();
      check($sformatf("vec%0d_ready", i), 32'(m_req_ready), 32'(vt[i].e_rdy));
      check($sformatf("vec%0d_sread", i), 32'(s_req_read), 32'(vt[i].e_sr));
      check($sformatf("vec%0d_swrite", i), 32'(s_req_write), 32'(vt[i].e_sw));
      check($sformatf("vec%0d_saddr", i), s_req_address, vt[i].e_sa);
      check($sformatf("vec%0d_sdata", i), s_req_data, vt[i].e_sd);
      check($sformatf("vec%0d_hart", i), 32'(hart_reset), 32'(vt[i].e_hart));
    end

    // Both masters read continuously: grants alternate, responses return in order.
    next_cycle();
    idle();
    set_m(0, 1'b1, 1'b0, 32'h100, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h200, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      sample();
      check("alt_ready", 32'(m_req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("alt_sread", 32'(s_req_read), 32'd1);
      check("alt_saddr", s_req_address, (i % 2 == 0) ? 32'h100 : 32'h200);
      tag_q.push_back(i % 2);
    end
    next_cycle();
    idle();
    for (int i = 0; i < 4; i++) begin
      slave_resp(32'hA + 32'(i));
      next_cycle();
    end
    drain("alt_drain");

    // FIFO full: fifth read blocks, and a pop frees the slot only on the next cycle.
    next_cycle();
    set_m(0, 1'b1, 1'b0, 32'h300, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) next_cycle();
      if (i == 4) slave_resp(32'h55);
      sample();
      check($sformatf("full%0d_ready", i), 32'(m_req_ready), (i == 4) ? 32'd0 : 32'd1);
      if (i != 4) tag_q.push_back(0);
    end
    next_cycle();
    idle();
    for (int i = 0; i < 4; i++) begin
      slave_resp(32'h60 + 32'(i));
      next_cycle();
    end
    drain("full_drain");

    // Control register write then read back.
    next_cycle();
    set_m(0, 1'b0, 1'b1, CTRL, 32'h1);
    sample();
    check("cw_ready", 32'(m_req_ready), 32'd1);
    check("cw_swrite", 32'(s_req_write), 32'd0);
    next_cycle();
    idle();
    sample();
    check("cw_hart", 32'(hart_reset), 32'd1);
    next_cycle();
    set_m(0, 1'b1, 1'b0, CTRL, 32'h0);
    sample();
    check("cr_ready", 32'(m_req_ready), 32'd1);
    check("cr_sread", 32'(s_req_read), 32'd0);
    push_exp(0, 32'h1);
    next_cycle();
    idle();
    drain("cr_drain");

    // Control read stalls behind two outstanding slave reads.
    next_cycle();
    set_m(1, 1'b1, 1'b0, 32'h400, 32'h0);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) next_cycle();
      sample();
      check("stall_rd_ready", 32'(m_req_ready), 32'd2);
      tag_q.push_back(1);
    end
    next_cycle();
    idle();
    set_m(0, 1'b1, 1'b0, CTRL, 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      if (i == 1) slave_resp(32'h71);
      if (i == 3) slave_resp(32'h72);
      sample();
      check($sformatf("stall%0d_ready", i), 32'(m_req_ready), (i == 4) ? 32'd1 : 32'd0);
      if (i == 4) push_exp(0, 32'h1);
    end
    next_cycle();
    idle();
    drain("stall_drain");

    // Asynchronous reset mid-burst clears FIFO, pointer and control register.
    next_cycle();
    set_m(0, 1'b1, 1'b0, 32'h500, 32'h0);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) next_cycle();
      sample();
      check("burst_ready", 32'(m_req_ready), 32'd1);
      tag_q.push_back(0);
    end
    next_cycle();
    idle();
    set_m(0, 1'b0, 1'b1, 32'h600, 32'h6);
    set_m(1, 1'b0, 1'b1, 32'h700, 32'h7);
    s_req_ready = 1'b0;
    reset_n = 1'b0;
    #2;
    check("mid_rst_res_valid", 32'(m_res_valid), 32'd0);
    check("mid_rst_hart", 32'(hart_reset), 32'd0);
    check("mid_rst_err", 32'(err_orphan), 32'd0);
    tag_q.delete();
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    next_cycle();
    s_req_ready = 1'b1;
    sample();
    check("post_rst_rr_ready", 32'(m_req_ready), 32'd1);
    check("post_rst_swrite", 32'(s_req_write), 32'd1);
    check("post_rst_saddr", s_req_address, 32'h600);
    next_cycle();
    idle();
    set_m(0, 1'b1, 1'b0, CTRL, 32'h0);
    sample();
    check("post_rst_fifo_empty", 32'(m_req_ready), 32'd1);
    push_exp(0, 32'h0);
    next_cycle();
    idle();
    drain("post_rst_drain");

    // Orphan response: dropped, sticky error flag.
    next_cycle();
    sample();
    check("orphan_pre", 32'(err_orphan), 32'd0);
    next_cycle();
    slave_resp(32'h99);
    sample();
    next_cycle();
    sample();
    check("orphan_set", 32'(err_orphan), 32'd1);
    repeat (3) next_cycle();
    sample();
    check("orphan_held", 32'(err_orphan), 32'd1);
    drain("orphan_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
